// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, bus layout and decoder state encoding
// for the display driver and the receive-side stream decoder.
package vga_timing_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_H_TOT  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int BUS_W     = 29;
  localparam int CNT_W     = 10;
  localparam int VGA_CLK_B = 28;
  localparam int HS_B      = 27;
  localparam int VS_B      = 26;
  localparam int BLANK_B   = 25;
  localparam int SYNC_B    = 24;
  localparam int R_HI = 23, R_LO = 16;
  localparam int G_HI = 15, G_LO = 8;
  localparam int B_HI = 7,  B_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKED
  } vga_state_e;

  function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters driven by recovered pixel strobes,
// with sync falling-edge detection against the previous strobe's levels.
module vga_sync_counter
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ps,
  input  logic             hs_n,
  input  logic             vs_n,
  output logic             hs_fall,
  output logic             vs_fall,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic [CNT_W-1:0] h_nxt,
  output logic [CNT_W-1:0] v_nxt
);

  logic hs_last;
  logic vs_last;

  assign hs_fall = ps & ~hs_n & hs_last;
  assign vs_fall = ps & ~vs_n & vs_last;

  // h_nxt/v_nxt are the position of the pixel on the current strobe.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (ps) begin
      if (hs_fall)
        h_nxt = '0;
      else if (h_cnt != '1)
        h_nxt = h_cnt + 1'b1;
      if (vs_fall)
        v_nxt = '0;
      else if (hs_fall)
        v_nxt = v_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      hs_last <= 1'b0;
      vs_last <= 1'b0;
    end else if (ps) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      hs_last <= hs_n;
      vs_last <= vs_n;
    end
  end

endmodule

// File: rtl/vga_stream_decoder.sv
// Receive-side VGA bus decoder: recovers pixel strobes, locks to the frame
// timing and emits per-pixel colour with (x, y), markers and timing errors.
module vga_stream_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  vga_output_data,
  output logic              pix_valid,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              line_start,
  output logic              frame_start,
  output logic              locked,
  output logic              h_err,
  output logic              v_err,
  output logic              blank_err,
  output logic [15:0]       frame_count
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_ACT0 = H_SYNC + H_BP;
  localparam int H_ACT1 = H_ACT0 + H_VIS - 1;
  localparam int V_ACT0 = V_SYNC + V_BP;
  localparam int V_ACT1 = V_ACT0 + V_VIS - 1;

  logic [BUS_W-1:0] s1;
  logic             s2_clk;   // only the vga_clk bit of the second stage is ever used
  logic             ps;
  logic             hs_fall, vs_fall;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [CNT_W-1:0] x_cur, y_cur;
  logic             active, blank_n, h_bad, v_bad, sync_unused;
  vga_state_e       state;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2_clk <= 1'b0;
    end else begin
      s1     <= vga_output_data;
      s2_clk <= s1[VGA_CLK_B];
    end
  end

  assign ps          = s1[VGA_CLK_B] & ~s2_clk;
  assign blank_n     = s1[BLANK_B];
  assign sync_unused = s1[SYNC_B];

  vga_sync_counter u_sync (
    .clk     (clk),
    .rst     (rst),
    .ps      (ps),
    .hs_n    (s1[HS_B]),
    .vs_n    (s1[VS_B]),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .h_nxt   (h_nxt),
    .v_nxt   (v_nxt)
  );

  assign active = in_range(h_nxt, H_ACT0, H_ACT1) && in_range(v_nxt, V_ACT0, V_ACT1);
  assign x_cur  = h_nxt - CNT_W'(H_ACT0);
  assign y_cur  = v_nxt - CNT_W'(V_ACT0);
  // A sync fall judges the length of the line/frame that just ended.
  assign h_bad  = hs_fall && (h_cnt != CNT_W'(H_TOT - 1));
  assign v_bad  = vs_fall && (v_cnt != CNT_W'(V_TOT - 1));
  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every output register is reset so the port is all-zero right after reset.
      state       <= ST_IDLE;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      blank_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      blank_err   <= 1'b0;
      if (ps) begin
        case (state)
          ST_IDLE: begin
            if (vs_fall)
              state <= ST_MEASURE;
          end
          ST_MEASURE, ST_LOCKED: begin
            h_err <= h_bad;
            v_err <= v_bad;
            if (h_bad || v_bad) begin
              state <= ST_IDLE;
            end else if (vs_fall) begin
              state <= ST_LOCKED;
              if (state == ST_LOCKED)
                frame_count <= frame_count + 16'd1;
            end
            if (state == ST_LOCKED) begin
              blank_err <= (blank_n != active);
              if (active && blank_n) begin
                pix_valid   <= 1'b1;
                pix_x       <= x_cur;
                pix_y       <= y_cur;
                pix_r       <= s1[R_HI:R_LO];
                pix_g       <= s1[G_HI:G_LO];
                pix_b       <= s1[B_HI:B_LO];
                line_start  <= (x_cur == '0);
                frame_start <= (x_cur == '0) && (y_cur == '0);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_decoder.sv
// Randomised-phase VGA stream bench for vga_stream_decoder on a shrunken
// timing, with a frame-level reference model feeding a scoreboard.
module tb_vga_stream_decoder;

  localparam int HV = 16, HF = 3, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [28:0] bus = '0;
  logic        pix_valid, line_start, frame_start, locked, h_err, v_err, blank_err;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [15:0] frame_count;

  vga_stream_decoder #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vga_output_data (bus),
    .pix_valid       (pix_valid),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_r           (pix_r),
    .pix_g           (pix_g),
    .pix_b           (pix_b),
    .line_start      (line_start),
    .frame_start     (frame_start),
    .locked          (locked),
    .h_err           (h_err),
    .v_err           (v_err),
    .blank_err       (blank_err),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        pv, herr, verr, berr, ls, fs, lk;
    int        x, y, fc;
    bit [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   mon_px, mon_ls, mon_fs, mon_herr, mon_verr, mon_berr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks line/frame lengths seen in the generated stream.
  int m_state;   // 0 unlocked, 1 measuring, 2 locked
  bit m_prev_hs, m_prev_vs;
  int m_line_px, m_frame_ln, m_fc;

  task automatic model_reset();
    m_state = 0; m_prev_hs = 0; m_prev_vs = 0;
    m_line_px = 0; m_frame_ln = 0; m_fc = 0;
  endtask

  task automatic model_pixel(input bit hs_n, input bit vs_n, input bit blank_n, input bit [23:0] rgb);
    bit   hf, vf, h_ok, v_ok, act;
    int   col, row;
    exp_t e;
    hf = !hs_n && m_prev_hs;
    vf = !vs_n && m_prev_vs;
    m_prev_hs = hs_n;
    m_prev_vs = vs_n;
    h_ok = !hf || (m_line_px == HT);
    v_ok = !vf || (m_frame_ln == VT);
    if (hf) m_line_px = 1; else m_line_px++;
    if (vf) m_frame_ln = 1; else if (hf) m_frame_ln++;
    col = m_line_px - 1 - (HS + HB);
    row = m_frame_ln - 1 - (VS + VB);
    act = (col >= 0) && (col < HV) && (row >= 0) && (row < VV);
    e = '{default: 0};
    e.herr = (m_state != 0) && !h_ok;
    e.verr = (m_state != 0) && !v_ok;
    if (m_state == 2) begin
      e.berr = (blank_n != act);
      e.pv   = act && blank_n;
    end
    if (e.pv) begin
      e.x = col; e.y = row; e.rgb = rgb;
      e.ls = (col == 0);
      e.fs = (col == 0) && (row == 0);
    end
    if (m_state == 0) begin
      if (vf) m_state = 1;
    end else if (e.herr || e.verr) begin
      m_state = 0;
    end else if (vf) begin
      if (m_state == 2) m_fc = (m_fc + 1) & 16'hffff;
      m_state = 2;
    end
    e.lk = (m_state == 2);
    e.fc = m_fc;
    if (e.pv || e.herr || e.verr || e.berr) sb.push_back(e);
  endtask

  // Monitor: every clk with a DUT event consumes one expected record.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_valid || h_err || v_err || blank_err) begin
        mon_px   += int'(pix_valid);
        mon_ls   += int'(line_start);
        mon_fs   += int'(frame_start);
        mon_herr += int'(h_err);
        mon_verr += int'(v_err);
        mon_berr += int'(blank_err);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: DUT event pv=%0b he=%0b ve=%0b be=%0b with no expected entry at %0t",
                   pix_valid, h_err, v_err, blank_err, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("evt_ctrl",
                {pix_valid, h_err, v_err, blank_err, line_start, frame_start, locked, frame_count},
                {e.pv, e.herr, e.verr, e.berr, e.ls, e.fs, e.lk, e.fc[15:0]});
          if (e.pv)
            check("evt_pixel", {pix_x, pix_y, pix_r, pix_g, pix_b},
                  {e.x[9:0], e.y[9:0], e.rgb});
        end
      end
    end
  end

  task automatic clear_counts();
    mon_px = 0; mon_ls = 0; mon_fs = 0; mon_herr = 0; mon_verr = 0; mon_berr = 0;
  endtask

  task automatic drive_pixel(input bit hs_n, input bit vs_n, input bit blank_n, input bit [23:0] rgb);
    int hi, lo;
    hi = int'($urandom_range(1, 2));
    lo = int'($urandom_range(1, 2));
    model_pixel(hs_n, vs_n, blank_n, rgb);
    bus = {1'b1, hs_n, vs_n, blank_n, 1'b1, rgb};
    repeat (hi) @(negedge clk);
    bus[28] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ctrl", {pix_valid, line_start, frame_start, locked, h_err, v_err, blank_err, frame_count}, '0);
    check("rst_pixel", {pix_x, pix_y, pix_r, pix_g, pix_b}, '0);
    rst = 1'b0;
    model_reset();
  endtask

  // cmode: 0 solid red, 1 position-encoded, 2 random colour.
  task automatic send_frame(input int first_row, input int lines, input int short_row,
                            input int cmode, input int bx, input int by, input int rst_row);
    for (int row = first_row; row < lines; row++) begin
      int len;
      if (row == rst_row) pulse_reset();
      len = (row == short_row) ? HT - 1 : HT;
      for (int col = 0; col < len; col++) begin
        int        x, y;
        bit        act;
        bit [23:0] rgb;
        x = col - (HS + HB);
        y = row - (VS + VB);
        act = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
        case (cmode)
          0:       rgb = 24'hFF0000;
          1:       rgb = {x[7:0], y[7:0], 8'h5A};
          default: rgb = 24'($urandom);
        endcase
        drive_pixel(!(col < HS), !(row < VS), act && !(x == bx && y == by), rgb);
      end
    end
  endtask

  initial begin
    model_reset();
    clear_counts();
    pulse_reset();
    repeat (3) @(negedge clk);

    // Tail of a frame so the first vs fall after reset is observed.
    send_frame(VT - 2, VT, -1, 2, -1, -1, -1);
    send_frame(0, VT, -1, 0, -1, -1, -1);
    check("unlocked_after_1st_vs", locked, 0);
    clear_counts();
    send_frame(0, VT, -1, 0, -1, -1, -1);
    check("locked_after_2nd_vs", locked, 1);
    check("px_red_frame", mon_px, HV * VV);
    check("fc_before_complete", frame_count, 0);

    clear_counts();
    send_frame(0, VT, -1, 1, -1, -1, -1);
    check("fc_first_frame", frame_count, 1);
    check("px_xy_frame", mon_px, HV * VV);
    check("line_starts", mon_ls, VV);
    check("frame_starts", mon_fs, 1);

    // Short line while locked, then relock one clean frame later.
    clear_counts();
    send_frame(0, VT, VS + VB + 3, 2, -1, -1, -1);
    check("h_err_count", mon_herr, 1);
    check("unlocked_after_h_err", locked, 0);
    send_frame(0, VT, -1, 2, -1, -1, -1);
    check("measuring_after_h_err", locked, 0);
    send_frame(0, VT, -1, 2, -1, -1, -1);
    check("relocked_after_h_err", locked, 1);

    // Frame one line short.
    clear_counts();
    send_frame(0, VT - 1, -1, 2, -1, -1, -1);
    send_frame(0, VT, -1, 2, -1, -1, -1);
    check("v_err_count", mon_verr, 1);
    check("unlocked_after_v_err", locked, 0);
    check("fc_held_on_v_err", frame_count, 3);
    send_frame(0, VT, -1, 2, -1, -1, -1);

    // Blanking forced low on one active pixel.
    clear_counts();
    send_frame(0, VT, -1, 2, 3, 2, -1);
    check("blank_err_count", mon_berr, 1);
    check("px_with_blank_hole", mon_px, HV * VV - 1);
    check("locked_through_blank", locked, 1);

    // Reset mid-frame, then one full measured frame to relock.
    send_frame(0, VT, -1, 2, -1, -1, VS + VB + 4);
    send_frame(0, VT, -1, 2, -1, -1, -1);
    check("measuring_after_rst", locked, 0);
    send_frame(0, VT, -1, 1, -1, -1, -1);
    check("relocked_after_rst", locked, 1);
    check("fc_after_rst", frame_count, 0);
    send_frame(0, VT, -1, 2, -1, -1, -1);
    send_frame(0, VT, -1, 2, -1, -1, -1);
    check("fc_final", frame_count, 2);

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
